// File: rtl/vec_stream_buf_if.sv
// Bundle of write/read stream, status and argmax signals for vec_stream_buf.
// The buffer uses the slave view; the environment driving it uses master.
interface vec_stream_buf_if #(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
);
    logic [IDX_W-1:0]  vec_len;
    logic              wr_val;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_rdy;
    logic              rd_val;
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_rdy;
    logic              fill_done;
    logic              drain_done;
    logic [IDX_W-1:0]  amax_idx;
    logic [DATA_W-1:0] amax_val;
    logic              idx_err;

    modport slave (
        input  vec_len, wr_val, wr_data, wr_idx, rd_rdy,
        output wr_rdy, rd_val, rd_data, rd_idx,
        output fill_done, drain_done, amax_idx, amax_val, idx_err
    );

    modport master (
        output vec_len, wr_val, wr_data, wr_idx, rd_rdy,
        input  wr_rdy, rd_val, rd_data, rd_idx,
        input  fill_done, drain_done, amax_idx, amax_val, idx_err
    );
endinterface

// File: rtl/vec_stream_buf.sv
// Inter-layer vector buffer: captures an indexed Q16.16 vector, tracks its
// signed argmax, then replays it in index order under downstream ready.
module vec_stream_buf #(
    parameter int LEN    = 1024,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    vec_stream_buf_if.slave bus
);
    localparam int LW = IDX_W + 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_PREF,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_latch;
    logic              r_first;
    logic              r_fill_done;
    logic              r_drain_done;
    logic              r_idx_err;
    logic [LW-1:0]     r_len;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_maxi;
    logic [DATA_W-1:0] r_amax_val;
    logic [IDX_W-1:0]  r_amax_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [LEN];

    logic              w_wr_rdy;
    logic              w_wr_acc;
    logic              w_in_rng;
    logic              w_wr_en;
    logic              w_last_wr;
    logic              w_rd_val;
    logic              w_xfer;
    logic              w_last_rd;
    logic              w_upd;
    logic [DATA_W-1:0] w_nmax;
    logic [IDX_W-1:0]  w_nmaxi;
    logic [LW-1:0]     w_len_in;
    logic [LW-1:0]     w_len_m1;
    logic [IDX_W-1:0]  w_raddr;

    // The first FILL cycle is spent latching len, so writes wait one cycle.
    assign w_wr_rdy  = (r_state == S_FILL) && !r_latch;
    assign w_wr_acc  = bus.wr_val && w_wr_rdy;
    assign w_len_m1  = r_len - LW'(1);
    assign w_in_rng  = {1'b0, bus.wr_idx} < r_len;
    assign w_wr_en   = w_wr_acc && w_in_rng;
    assign w_last_wr = w_wr_en && ({1'b0, bus.wr_idx} == w_len_m1);
    assign w_rd_val  = (r_state == S_DRAIN);
    assign w_xfer    = w_rd_val && bus.rd_rdy;
    assign w_last_rd = w_xfer && ({1'b0, r_rd_idx} == w_len_m1);
    assign w_len_in  = (bus.vec_len == '0) ? LW'(LEN) : {1'b0, bus.vec_len};

    // Strict compare keeps the earlier element on a tie.
    assign w_upd   = r_first || ($signed(bus.wr_data) > $signed(r_max));
    assign w_nmax  = w_upd ? bus.wr_data : r_max;
    assign w_nmaxi = w_upd ? bus.wr_idx : r_maxi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_raddr = r_rd_idx;
        unique case (r_state)
            S_FILL: begin
                if (w_last_wr) begin
                    w_next = S_PREF;
                end
            end
            S_PREF: begin
                w_next  = S_DRAIN;
                w_raddr = '0;
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    w_raddr = r_rd_idx + IDX_W'(1);
                end
                if (w_last_rd) begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_latch      <= 1'b1;
            r_first      <= 1'b1;
            r_len        <= '0;
            r_max        <= '0;
            r_maxi       <= '0;
            r_amax_val   <= '0;
            r_amax_idx   <= '0;
            r_fill_done  <= 1'b0;
            r_drain_done <= 1'b0;
            r_idx_err    <= 1'b0;
            r_rd_idx     <= '0;
        end else begin
            r_fill_done  <= w_last_wr;
            r_drain_done <= w_last_rd;
            if ((r_state == S_FILL) && r_latch) begin
                r_len   <= w_len_in;
                r_latch <= 1'b0;
            end
            if (w_wr_acc && !w_in_rng) begin
                r_idx_err <= 1'b1;
            end
            if (w_wr_en) begin
                r_first <= 1'b0;
                r_max   <= w_nmax;
                r_maxi  <= w_nmaxi;
            end
            if (w_last_wr) begin
                r_amax_val <= w_nmax;
                r_amax_idx <= w_nmaxi;
            end
            if (r_state == S_PREF) begin
                r_rd_idx <= '0;
            end else if (w_xfer) begin
                r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
            if (w_last_rd) begin
                r_latch <= 1'b1;
                r_first <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[bus.wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_raddr];
        end
    end

    assign bus.wr_rdy     = w_wr_rdy;
    assign bus.rd_val     = w_rd_val;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_idx     = r_rd_idx;
    assign bus.fill_done  = r_fill_done;
    assign bus.drain_done = r_drain_done;
    assign bus.amax_idx   = r_amax_idx;
    assign bus.amax_val   = r_amax_val;
    assign bus.idx_err    = r_idx_err;
endmodule
